key_counter_4bit: RTL and testbench
===================================

# key_counter_4bit

Debounced up/down counter that produces the 4-bit value consumed by the binary-to-BCD display stage. Two raw active-low pushbuttons are synchronised, debounced and edge-detected. Each accepted press steps the count by one, with wrap-around at a configurable limit. A synchronous load path presets the count. `Q` connects directly to the converter's 4-bit input.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a level change (10 ms at 50 MHz). Minimum 2.
- `MAX_VALUE`, default 15: highest count value, range 1..15. Set 9 for decimal-only display.
- `CLOCK_50` in 1: single clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `KEY_UP_N` in 1: raw up button, active-low, asynchronous to the clock.
- `KEY_DOWN_N` in 1: raw down button, active-low, asynchronous to the clock.
- `LOAD` in 1: synchronous preset strobe, sampled every cycle.
- `LOAD_VALUE` in 4: preset value.
- `Q` out 4: current count. Feeds the BCD converter.
- `STEP` out 1: one-cycle pulse whenever `Q` changes due to a button.
- `WRAP` out 1: one-cycle pulse when a step wraps (MAX_VALUE→0 or 0→MAX_VALUE).

## Operation
- Reset values:
  - `Q`=0, `STEP`=0, `WRAP`=0.
  - Synchroniser flops = 1 (released).
  - Debouncers in RELEASED, stable counters = 0.
- Synchroniser: two flops per button. Apply inversion after synchronisation, so the internal `pressed` signal is active-high.
- Debouncer FSM, one per button:
  - RELEASED: on `pressed`=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: while `pressed`=1, increment cnt. When cnt reaches DEBOUNCE_CYCLES, go to HELD and emit a one-cycle `press` pulse. Any `pressed`=0 sample returns to RELEASED with cnt=0.
  - HELD: on `pressed`=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: symmetric to PRESS_WAIT. Reaching DEBOUNCE_CYCLES goes to RELEASED with no pulse. A `pressed`=1 sample returns to HELD.
  - Holding a button produces exactly one step. There is no auto-repeat.
- Counter update, in priority order each cycle:
  1. `LOAD`=1: `Q` ← min(`LOAD_VALUE`, MAX_VALUE). `STEP`=0, `WRAP`=0. Any press pulse in the same cycle is discarded.
  2. Up and down press pulses in the same cycle: `Q` unchanged, no pulses.
  3. Up pulse:
     - If `Q`=MAX_VALUE, `Q`←0 and `WRAP`=1.
     - Otherwise `Q`←`Q`+1.
     - `STEP`=1 in either case.
  4. Down pulse:
     - If `Q`=0, `Q`←MAX_VALUE and `WRAP`=1.
     - Otherwise `Q`←`Q`−1.
     - `STEP`=1 in either case.
- Arithmetic is 4-bit unsigned. Compute wrap by comparison, never by natural overflow, so a MAX_VALUE below 15 is honoured.
- If `Q` > MAX_VALUE ever occurs, the next up step goes to 0 (treated as wrap). It is unreachable after reset.
- `RESET` asserted mid-debounce or mid-press: immediate return to reset values. After release, a button already held low must be re-accepted through a full PRESS_WAIT before it can produce a pulse.

## Timing
- Raw press to `Q` change: 2 (sync) + DEBOUNCE_CYCLES (stability) + 1 (register) cycles. `STEP`/`WRAP` are asserted in the same cycle `Q` first shows the new value.
- `LOAD` to `Q`: 1 cycle (registered).
- `Q`, `STEP` and `WRAP` are all registered outputs, with no combinational path from inputs.
- A glitch shorter than DEBOUNCE_CYCLES after synchronisation never changes `Q`.
- Minimum press-to-press interval: 2×DEBOUNCE_CYCLES cycles (press acceptance plus release acceptance).

## Structure
- Shared package `key_counter_pkg`:
  - Debouncer state typedef: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Constant `COUNT_W`=4.
  - Default `DEBOUNCE_CYCLES` constant.
- Sub-module `key_debouncer`:
  - Contains the synchroniser, debounce FSM and counter, and the press-pulse output.
  - Parameterised by DEBOUNCE_CYCLES; the counter width is derived as clog2(DEBOUNCE_CYCLES+1).
  - Instantiated twice.
- The top level holds the count register, priority logic and pulse outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, MAX_VALUE=15 unless stated.
- Reset then idle 20 cycles → `Q`=0, `STEP`=0, `WRAP`=0 throughout.
- Hold `KEY_UP_N` low 30 cycles, then release → exactly one `STEP` pulse 7 cycles after the falling edge; `Q`=1.
- Bounce `KEY_UP_N` low 3 cycles / high 1 cycle ×5, then low steady → single step only after the steady period; `Q`=1.
- LOAD with `LOAD_VALUE`=15, then one up press → `Q`=0 with `WRAP`=1 and `STEP`=1. Then one down press → `Q`=15 with `WRAP`=1.
- MAX_VALUE=9, LOAD with `LOAD_VALUE`=12 → `Q`=9. Then one up press → `Q`=0 with `WRAP`=1.
- Both buttons accepted in the same cycle → `Q` unchanged, no pulses. `LOAD` coincident with an up pulse → `Q`=`LOAD_VALUE`, no `STEP`. `RESET` at cycle 3 of PRESS_WAIT → `Q`=0, and no step until a fresh 4-cycle stable press after reset release.

Source files
------------

// File: rtl/key_counter_pkg.sv
// Shared definitions for the debounced up/down key counter.
package key_counter_pkg;

    localparam int unsigned COUNT_W                 = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef logic [1:0] deb_state_t;

    localparam deb_state_t RELEASED     = 2'd0;
    localparam deb_state_t PRESS_WAIT   = 2'd1;
    localparam deb_state_t HELD         = 2'd2;
    localparam deb_state_t RELEASE_WAIT = 2'd3;

    function automatic logic [COUNT_W-1:0] clamp_to_max(
        input logic [COUNT_W-1:0] value,
        input logic [COUNT_W-1:0] max_value
    );
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/key_counter_4bit_if.sv
// Button and preset signals feeding key_counter_4bit, bundled for the driver side.
interface key_counter_4bit_if;

    logic                                  key_up_n;
    logic                                  key_down_n;
    logic                                  load;
    logic [key_counter_pkg::COUNT_W-1:0]   load_value;

    modport master (
        output key_up_n,
        output key_down_n,
        output load,
        output load_value
    );

    modport slave (
        input key_up_n,
        input key_down_n,
        input load,
        input load_value
    );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus debounce FSM for one active-low pushbutton;
// emits a single-cycle press pulse when a press is accepted.
module key_debouncer
    import key_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             pressed;
    logic [CNT_W-1:0] cnt_inc;

    // Inversion after synchronisation keeps the flops at 1 while released.
    assign pressed = ~sync_q[1];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/key_counter_4bit.sv
// Debounced up/down counter with wrap at MAX_VALUE and a synchronous preset;
// Q drives the binary-to-BCD display stage.
module key_counter_4bit
    import key_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned MAX_VALUE       = 15
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               KEY_UP_N,
    input  logic               KEY_DOWN_N,
    input  logic               LOAD,
    input  logic [COUNT_W-1:0] LOAD_VALUE,
    output logic [COUNT_W-1:0] Q,
    output logic               STEP,
    output logic               WRAP
);

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_VALUE);

    logic               up_press;
    logic               down_press;
    logic [COUNT_W-1:0] q_q, q_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up_debouncer (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .key_n_i (KEY_UP_N),
        .press_o (up_press)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_down_debouncer (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .key_n_i (KEY_DOWN_N),
        .press_o (down_press)
    );

    always_comb begin
        q_d    = q_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (LOAD) begin
            q_d = clamp_to_max(LOAD_VALUE, MAX_C);
        end else if (up_press != down_press) begin
            step_d = 1'b1;
            if (up_press) begin
                // >= also recovers an out-of-range count by wrapping to 0.
                if (q_q >= MAX_C) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + COUNT_W'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = MAX_C;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - COUNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            q_q    <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign STEP = step_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_key_counter_4bit.sv
// Bench for key_counter_4bit: two instances (MAX_VALUE 15 and 9) share stimulus
// and are compared every cycle against an event-scheduled arithmetic model.
module tb_key_counter_4bit;

    localparam int unsigned DC      = 4;
    localparam int          LATENCY = 2 + DC + 1;
    localparam int          K_UP    = 0;
    localparam int          K_DOWN  = 1;
    localparam int          K_LOAD  = 2;

    typedef struct {
        int at;
        int kind;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_counter_4bit_if bus ();

    logic [3:0] q15, q9;
    logic       step15, step9, wrap15, wrap9;

    key_counter_4bit #(
        .DEBOUNCE_CYCLES(DC),
        .MAX_VALUE(15)
    ) dut15 (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .KEY_UP_N   (bus.key_up_n),
        .KEY_DOWN_N (bus.key_down_n),
        .LOAD       (bus.load),
        .LOAD_VALUE (bus.load_value),
        .Q          (q15),
        .STEP       (step15),
        .WRAP       (wrap15)
    );

    key_counter_4bit #(
        .DEBOUNCE_CYCLES(DC),
        .MAX_VALUE(9)
    ) dut9 (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .KEY_UP_N   (bus.key_up_n),
        .KEY_DOWN_N (bus.key_down_n),
        .LOAD       (bus.load),
        .LOAD_VALUE (bus.load_value),
        .Q          (q9),
        .STEP       (step9),
        .WRAP       (wrap9)
    );

    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  mx[2] = '{15, 9};
    int  eq[2] = '{0, 0};
    int  estep[2] = '{0, 0};
    int  ewrap[2] = '{0, 0};
    ev_t evq[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic schedule(input int at, input int kind, input int val);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.val  = val;
        evq.push_back(e);
    endtask

    task automatic check_all();
        check("q15", 8'(q15), 8'(eq[0]));
        check("step15", 8'(step15), 8'(estep[0]));
        check("wrap15", 8'(wrap15), 8'(ewrap[0]));
        check("q9", 8'(q9), 8'(eq[1]));
        check("step9", 8'(step9), 8'(estep[1]));
        check("wrap9", 8'(wrap9), 8'(ewrap[1]));
    endtask

    // One clock: apply accepted events due this cycle to the model, then compare.
    task automatic tick();
        bit up, dn, ld;
        int lv;
        up = 0; dn = 0; ld = 0; lv = 0;
        @(posedge clk);
        cyc++;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at == cyc) begin
                if (evq[i].kind == K_UP) up = 1;
                else if (evq[i].kind == K_DOWN) dn = 1;
                else begin
                    ld = 1;
                    lv = evq[i].val;
                end
                evq.delete(i);
            end
        end
        for (int d = 0; d < 2; d++) begin
            estep[d] = 0;
            ewrap[d] = 0;
            if (ld) begin
                eq[d] = (lv > mx[d]) ? mx[d] : lv;
            end else if (up && !dn) begin
                estep[d] = 1;
                if (eq[d] == mx[d]) begin
                    eq[d] = 0;
                    ewrap[d] = 1;
                end else eq[d] = eq[d] + 1;
            end else if (dn && !up) begin
                estep[d] = 1;
                if (eq[d] == 0) begin
                    eq[d] = mx[d];
                    ewrap[d] = 1;
                end else eq[d] = eq[d] - 1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_keys(input int which, input logic level);
        if (which == K_UP || which == 2) bus.key_up_n = level;
        if (which == K_DOWN || which == 2) bus.key_down_n = level;
    endtask

    // which: 0 up, 1 down, 2 both together
    task automatic press(input int which, input int hold);
        drive_keys(which, 1'b0);
        if (which == K_UP || which == 2) schedule(cyc + LATENCY, K_UP, 0);
        if (which == K_DOWN || which == 2) schedule(cyc + LATENCY, K_DOWN, 0);
        ticks(hold);
        drive_keys(which, 1'b1);
        ticks(10);
    endtask

    task automatic glitch(input int which, input int len);
        drive_keys(which, 1'b0);
        ticks(len);
        drive_keys(which, 1'b1);
        ticks(10);
    endtask

    task automatic do_load(input int v);
        bus.load       = 1'b1;
        bus.load_value = 4'(v);
        schedule(cyc + 1, K_LOAD, v);
        tick();
        bus.load = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        evq.delete();
        for (int d = 0; d < 2; d++) begin
            eq[d] = 0;
            estep[d] = 0;
            ewrap[d] = 0;
        end
        #1;
        check_all();
        ticks(n);
        rst = 1'b0;
    endtask

    initial begin
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = 4'd0;
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;

        // idle after reset
        ticks(20);

        // long hold: one step, seven cycles after the falling edge
        press(K_UP, 30);

        // bounce then steady press
        for (int b = 0; b < 5; b++) begin
            bus.key_up_n = 1'b0;
            ticks(3);
            bus.key_up_n = 1'b1;
            ticks(1);
        end
        press(K_UP, 12);

        // wrap both ways at 15; instance with MAX 9 clamps the load
        do_load(15);
        ticks(2);
        press(K_UP, 8);
        press(K_DOWN, 8);

        // load above 9, then up wraps on the MAX 9 instance
        do_load(12);
        ticks(2);
        press(K_UP, 8);

        // simultaneous accept cancels
        press(2, 8);

        // load coincident with an accepted up press
        bus.key_up_n = 1'b0;
        schedule(cyc + LATENCY, K_UP, 0);
        ticks(LATENCY - 1);
        do_load(5);
        ticks(6);
        bus.key_up_n = 1'b1;
        ticks(10);

        // reset during PRESS_WAIT with the key still held
        bus.key_up_n = 1'b0;
        ticks(5);
        apply_reset(3);
        schedule(cyc + LATENCY, K_UP, 0);
        ticks(12);
        bus.key_up_n = 1'b1;
        ticks(10);

        // randomized mix
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1: press(K_UP, int'($urandom_range(5, 15)));
                2: press(K_DOWN, int'($urandom_range(5, 15)));
                3: glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, DC - 1)));
                4: begin
                    do_load(int'($urandom_range(0, 15)));
                    ticks(2);
                end
                default: press(2, int'($urandom_range(5, 10)));
            endcase
        end
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
